// File: rtl/clk_div_pkg.sv
// Shared constants, channel mode encoding and index-width helper for the
// multi-channel programmable clock divider.
package clk_div_pkg;

  localparam int unsigned CLKDIV_MIN_DIV = 2;
  localparam int unsigned CLKDIV_MAX_NCH = 8;

  typedef enum logic [1:0] {
    CH_PARK,
    CH_RUN,
    CH_SYNC
  } ch_mode_e;

  // One extra bit so that out-of-range indices (>= NCH) are representable and rejectable.
  function automatic int unsigned clkdiv_ch_w(input int unsigned nch);
    return $clog2(nch) + 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, shadow divisor register, boundary-only
// apply logic and registered clk_out/tick decode.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned CW          = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          enable,
  input  logic          sync,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_val,
  output logic          pending,
  output logic          clk_out,
  output logic          tick
);

  localparam logic [CW-1:0] DEF_DIV = CW'(DEFAULT_DIV);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0] cnt_q, div_q, pend_div_q;
  logic [CW-1:0] cnt_d, div_d, pend_div_d;
  logic          pend_flag_q, clk_out_q, tick_q;
  logic          pend_flag_d, clk_out_d, tick_d;
  logic          at_term, apply;
  ch_mode_e      mode;

  always_comb begin
    mode = CH_PARK;
    if (enable) mode = sync ? CH_SYNC : CH_RUN;

    at_term = (cnt_q == (div_q - ONE));
    // A sync pulse forces a boundary on enabled channels, so pending values land there too.
    apply   = pend_flag_q && (at_term || (mode == CH_SYNC));
    div_d   = apply ? pend_div_q : div_q;

    cnt_d     = div_d - ONE;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;
    case (mode)
      CH_RUN: begin
        cnt_d     = at_term ? '0 : (cnt_q + ONE);
        clk_out_d = (cnt_d < (div_d >> 1));
        tick_d    = (cnt_d == '0);
      end
      CH_SYNC: begin
        cnt_d     = '0;
        clk_out_d = 1'b1;
        tick_d    = 1'b1;
      end
      default: ;
    endcase

    pend_div_d  = pend_div_q;
    pend_flag_d = pend_flag_q;
    if (wr_en) begin
      pend_div_d  = wr_val;
      pend_flag_d = 1'b1;
    end else if (apply) begin
      pend_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q       <= DEF_DIV - ONE;
      div_q       <= DEF_DIV;
      pend_div_q  <= DEF_DIV;
      pend_flag_q <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      pend_div_q  <= pend_div_d;
      pend_flag_q <= pend_flag_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
    end
  end

  assign pending = pend_flag_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_prog_multi.sv
// Multi-channel programmable clock divider top: write decode, reject check, div_err,
// channel array. Define CLKDIV_SYNC_EN to add the sync_in phase-align input.
module clk_div_prog_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter int unsigned CW          = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic [NCH-1:0]                enable,
  input  logic                          div_wr,
  input  logic [clkdiv_ch_w(NCH)-1:0]   div_wr_ch,
  input  logic [CW-1:0]                 div_wr_val,
`ifdef CLKDIV_SYNC_EN
  input  logic                          sync_in,
`endif
  output logic                          div_err,
  output logic [NCH-1:0]                div_pending,
  output logic [NCH-1:0]                clk_out,
  output logic [NCH-1:0]                tick
);

  localparam int unsigned CHW = clkdiv_ch_w(NCH);

  logic           wr_ok, wr_reject, sync_w, div_err_q;
  logic [NCH-1:0] wr_sel;

`ifdef CLKDIV_SYNC_EN
  assign sync_w = sync_in;
`else
  assign sync_w = 1'b0;
`endif

  always_comb begin
    wr_ok     = div_wr && (div_wr_ch < CHW'(NCH)) && (div_wr_val >= CW'(CLKDIV_MIN_DIV));
    wr_reject = div_wr && !wr_ok;
    wr_sel    = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      wr_sel[k] = wr_ok && (div_wr_ch == CHW'(k));
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) div_err_q <= 1'b0;
    else     div_err_q <= wr_reject;
  end

  assign div_err = div_err_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    clk_div_channel #(
      .CW          (CW),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in  (clk_in),
      .rst     (rst),
      .enable  (enable[k]),
      .sync    (sync_w),
      .wr_en   (wr_sel[k]),
      .wr_val  (div_wr_val),
      .pending (div_pending[k]),
      .clk_out (clk_out[k]),
      .tick    (tick[k])
    );
  end

endmodule

// File: tb/tb_clk_div_prog_multi.sv
// Scoreboard bench for clk_div_prog_multi: a period/elapsed-time reference model
// predicts each cycle's outputs; a monitor pops and compares after every edge.
module tb_clk_div_prog_multi;

  localparam int NCH    = 2;
  localparam int CW     = 8;
  localparam int DEFDIV = 4;
  localparam int CHW    = 2;

  logic           clk_in = 1'b0;
  logic           rst;
  logic [NCH-1:0] enable;
  logic           div_wr;
  logic [CHW-1:0] div_wr_ch;
  logic [CW-1:0]  div_wr_val;
  logic           sync_in;
  logic           div_err;
  logic [NCH-1:0] div_pending, clk_out, tick;

  always #5 clk_in = ~clk_in;

  clk_div_prog_multi #(
    .NCH         (NCH),
    .CW          (CW),
    .DEFAULT_DIV (DEFDIV)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .enable      (enable),
    .div_wr      (div_wr),
    .div_wr_ch   (div_wr_ch),
    .div_wr_val  (div_wr_val),
`ifdef CLKDIV_SYNC_EN
    .sync_in     (sync_in),
`endif
    .div_err     (div_err),
    .div_pending (div_pending),
    .clk_out     (clk_out),
    .tick        (tick)
  );

  typedef struct packed {
    logic           err;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] clk;
    logic [NCH-1:0] tck;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: each channel is "a period of m_per cycles that began at edge m_start".
  int m_run[NCH], m_start[NCH], m_per[NCH], m_pend[NCH], m_pflag[NCH];
  int n = 0;

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_run[k] = 0; m_start[k] = 0; m_per[k] = DEFDIV; m_pend[k] = 0; m_pflag[k] = 0;
    end
  endtask

  function automatic bit boundary_at(int k, int edge_n);
    return (m_run[k] == 0) || (edge_n - m_start[k] == m_per[k]);
  endfunction

  task automatic step(input logic [NCH-1:0] en, input bit wr, input int ch, input int val,
                      input bit sy);
    exp_t e;
    bit   bnd, syn, eff_sync, ok;
    int   el;
    @(negedge clk_in);
    enable = en; div_wr = wr; div_wr_ch = CHW'(ch); div_wr_val = CW'(val); sync_in = sy;
`ifdef CLKDIV_SYNC_EN
    eff_sync = sy;
`else
    eff_sync = 1'b0;
`endif
    n++;
    e = '0;
    for (int k = 0; k < NCH; k++) begin
      bnd = boundary_at(k, n);
      syn = eff_sync && en[k];
      if (m_pflag[k] != 0 && (bnd || syn)) begin
        m_per[k] = m_pend[k]; m_pflag[k] = 0;
      end
      if (en[k]) begin
        if (bnd || syn) m_start[k] = n;
        m_run[k]  = 1;
        el        = n - m_start[k];
        e.tck[k]  = (el == 0);
        e.clk[k]  = (el < m_per[k] / 2);
      end else begin
        m_run[k] = 0;
      end
    end
    ok = wr && (ch < NCH) && (val >= 2);
    if (ok) begin
      m_pend[ch] = val; m_pflag[ch] = 1;
    end
    e.err = wr && !ok;
    for (int k = 0; k < NCH; k++) e.pend[k] = (m_pflag[k] != 0);
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [NCH-1:0] en, input int cycles);
    for (int i = 0; i < cycles; i++) step(en, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if ({div_err, div_pending, clk_out, tick} !== '0) begin
      miscompares++;
      $display("FAIL %s: got err=%b pend=%b clk=%b tick=%b, need all 0",
               name, div_err, div_pending, clk_out, tick);
    end
  endtask

  // Monitor: the DUT presents a fresh output word after every clock edge.
  initial begin : monitor
    exp_t e, got;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{err: div_err, pend: div_pending, clk: clk_out, tck: tick};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL cycle%0d: got err=%b pend=%b clk=%b tick=%b, need err=%b pend=%b clk=%b tick=%b",
                   vectors, got.err, got.pend, got.clk, got.tck, e.err, e.pend, e.clk, e.tck);
        end
      end
    end
  end

  task automatic random_steps(input int count);
    logic [NCH-1:0] en;
    bit  wr, sy;
    int  ch, val, r;
    en = enable;
    for (int i = 0; i < count; i++) begin
      for (int k = 0; k < NCH; k++) if ($urandom_range(0, 39) == 0) en[k] = ~en[k];
      wr = ($urandom_range(0, 11) == 0);
      r  = $urandom_range(0, 9);
      ch = (r == 0) ? 2 + $urandom_range(0, 1) : $urandom_range(0, NCH - 1);
      r  = $urandom_range(0, 9);
      if (r == 0)      val = $urandom_range(0, 1);
      else if (r == 1) val = $urandom_range(2, 255);
      else             val = $urandom_range(2, 9);
      sy = ($urandom_range(0, 49) == 0);
      step(en, wr, ch, val, sy);
    end
  endtask

  initial begin : stimulus
    int guard;
    rst = 1'b1; enable = '0; div_wr = 1'b0; div_wr_ch = '0; div_wr_val = '0; sync_in = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset_state");
    @(negedge clk_in);
    rst = 1'b0;

    // Default divisor on ch0: 1,1,0,0 with a tick every 4th cycle.
    idle(2'b01, 10);
    // Pending write mid-period on ch0; current period completes first.
    step(2'b01, 1'b1, 0, 7, 1'b0);
    idle(2'b01, 20);
    // Rejected writes: bad channel and too-small divisors.
    step(2'b01, 1'b1, 2, 5, 1'b0);
    step(2'b01, 1'b1, 0, 0, 1'b0);
    step(2'b01, 1'b1, 0, 1, 1'b0);
    step(2'b01, 1'b1, 3, 9, 1'b0);
    idle(2'b01, 6);
    // Parked ch1 applies immediately, then runs 5-cycle periods.
    step(2'b01, 1'b1, 1, 5, 1'b0);
    idle(2'b01, 2);
    idle(2'b11, 16);
    // Maximum divisor: one full 255-cycle period plus the next.
    step(2'b11, 1'b1, 0, 255, 1'b0);
    idle(2'b11, 530);
    // Write landing on the same edge as an apply.
    step(2'b11, 1'b1, 0, 3, 1'b0);
    guard = 0;
    while (!boundary_at(0, n + 1) && guard < 400) begin
      step(2'b11, 1'b0, 0, 0, 1'b0);
      guard++;
    end
    step(2'b11, 1'b1, 0, 5, 1'b0);
    idle(2'b11, 14);
    // Disable mid-period, then re-enable.
    idle(2'b10, 3);
    idle(2'b11, 8);
`ifdef CLKDIV_SYNC_EN
    step(2'b11, 1'b1, 0, 4, 1'b0);
    step(2'b11, 1'b1, 1, 6, 1'b0);
    idle(2'b11, 11);
    step(2'b11, 1'b0, 0, 0, 1'b1);
    idle(2'b11, 14);
`endif

    random_steps(2500);

    // Asynchronous reset away from the clock edge.
    @(posedge clk_in);
    #3;
    rst = 1'b1;
    enable = '0; div_wr = 1'b0; sync_in = 1'b0;
    #1;
    check_reset_outputs("async_reset_mid");
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    idle(2'b11, 10);
    random_steps(800);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk_in);
      guard++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d outstanding, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
